// File: rtl/prirv32_pkg.sv
// prirv32_pkg: shared definitions for the priRV32 load/store unit.
//   - lsu_state_e : FSM state encoding (IDLE, REQ, RESP)
//   - OP_*        : bit positions of the one-hot opcode slice {lb,lh,lw,lbu,lhu,sb,sh,sw}
//   - lsu_op_e    : compact opcode held internally after priority decode
//   - WSTRB_*     : base byte-strobe patterns, shifted into place per lane
//   - helpers     : opcode decode, size classification, alignment helpers
package prirv32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // lb is the MSB of the slice, sw the LSB.
  localparam int OP_LB  = 7;
  localparam int OP_LH  = 6;
  localparam int OP_LW  = 5;
  localparam int OP_LBU = 4;
  localparam int OP_LHU = 3;
  localparam int OP_SB  = 2;
  localparam int OP_SH  = 1;
  localparam int OP_SW  = 0;

  typedef enum logic [2:0] {
    LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW
  } lsu_op_e;

  localparam logic [3:0] WSTRB_BYTE = 4'b0001;
  localparam logic [3:0] WSTRB_HALF = 4'b0011;
  localparam logic [3:0] WSTRB_WORD = 4'b1111;

  // When several opcode bits are set, the first one in listed order (lb) wins.
  // Caller guarantees at least one bit is set.
  function automatic lsu_op_e op_decode(input logic [7:0] op);
    lsu_op_e r;
    if (op[OP_LB])       r = LSU_LB;
    else if (op[OP_LH])  r = LSU_LH;
    else if (op[OP_LW])  r = LSU_LW;
    else if (op[OP_LBU]) r = LSU_LBU;
    else if (op[OP_LHU]) r = LSU_LHU;
    else if (op[OP_SB])  r = LSU_SB;
    else if (op[OP_SH])  r = LSU_SH;
    else                 r = LSU_SW;
    return r;
  endfunction

  function automatic logic op_is_load(input lsu_op_e op);
    return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
           (op == LSU_LBU) || (op == LSU_LHU);
  endfunction

  function automatic logic op_is_half(input lsu_op_e op);
    return (op == LSU_LH) || (op == LSU_LHU) || (op == LSU_SH);
  endfunction

  function automatic logic op_is_word(input lsu_op_e op);
    return (op == LSU_LW) || (op == LSU_SW);
  endfunction

  // Clear the low address bits that the access size cannot use.
  function automatic logic [1:0] align_low(input lsu_op_e op, input logic [1:0] lo);
    logic [1:0] r;
    if (op_is_word(op))      r = 2'b00;
    else if (op_is_half(op)) r = {lo[1], 1'b0};
    else                     r = lo;
    return r;
  endfunction

  function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] lo);
    logic r;
    if (op_is_word(op))      r = (lo != 2'b00);
    else if (op_is_half(op)) r = lo[0];
    else                     r = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/prirv32_lsu_align.sv
// prirv32_lsu_align: combinational lane steering for the load/store unit.
// Ports:
//   op         in  opcode of the access in flight
//   addr_lo    in  byte offset within the word (already size-aligned)
//   wdata      in  raw store data (rs2)
//   rdata      in  raw word from the data bus
//   wstrb      out byte strobes (0 for loads)
//   store_data out store data replicated across lanes
//   load_data  out shifted and sign/zero-extended load result
module prirv32_lsu_align
  import prirv32_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    wstrb      = 4'b0000;
    store_data = 32'h0;
    load_data  = 32'h0;
    case (op)
      LSU_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      LSU_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      LSU_LW:  load_data = shifted;
      LSU_LBU: load_data = {24'h0, shifted[7:0]};
      LSU_LHU: load_data = {16'h0, shifted[15:0]};
      LSU_SB: begin
        wstrb      = WSTRB_BYTE << addr_lo;
        store_data = {4{wdata[7:0]}};
      end
      LSU_SH: begin
        wstrb      = WSTRB_HALF << {addr_lo[1], 1'b0};
        store_data = {2{wdata[15:0]}};
      end
      LSU_SW: begin
        wstrb      = WSTRB_WORD;
        store_data = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/prirv32_lsu.sv
// prirv32_lsu: single-beat load/store unit behind the execute stage.
// Optional feature macro: PRIRV32_MISALIGN_TRAP_EN
//   defined   -> misaligned lh/lhu/sh/lw/sw skip the bus and report misalign_o
//   undefined -> offending low address bits are cleared, misalign_o stays 0
// Parameter: TIMEOUT_CYCLES (1..65535) REQ cycles without ready before abort.
// Ports:
//   clk_i, rst_n                    clock, async active-low reset
//   start_i, lsu_op_i, addr_i,
//   wdata_i, rd_i                   request from execute (sampled in IDLE)
//   busy_o, done_o, err_o,
//   misalign_o                      status; done_o is a one-cycle pulse
//   rd_wr_en_o, rd_o, rd_wdata_o    register-file write port
//   mem_valid_o, mem_ready_i,
//   mem_addr_o, mem_wdata_o,
//   mem_wstrb_o, mem_rdata_i        data-memory port
// Bus handshake: mem_valid_o is held high with mem_addr/wdata/wstrb stable
// until the cycle mem_ready_i is sampled high; mem_rdata_i is valid in that
// same cycle and is captured on that clock edge.
module prirv32_lsu
  import prirv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  lsu_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        rd_wr_en_o,
  output logic [4:0]  rd_o,
  output logic [31:0] rd_wdata_o,
  output logic        err_o,
  output logic        misalign_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES);

  lsu_state_e  state_q, state_d;
  lsu_op_e     op_q, op_in;
  logic [31:0] addr_q, wdata_q;
  logic [4:0]  rd_q;
  logic        err_q, mis_q;
  logic [15:0] cnt_q;
  logic        accept, trap;
  logic [3:0]  wstrb;
  logic [31:0] store_data, load_data;

  assign op_in  = op_decode(lsu_op_i);
  assign accept = (state_q == ST_IDLE) && start_i && (lsu_op_i != 8'h00);

`ifdef PRIRV32_MISALIGN_TRAP_EN
  assign trap = is_misaligned(op_in, addr_i[1:0]);
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = trap ? ST_RESP : ST_REQ;
      // Ready is checked before the counter so a ready on the last
      // allowed cycle still counts as success.
      ST_REQ: begin
        if (mem_ready_i)             state_d = ST_RESP;
        else if (cnt_q == TMO_LAST)  state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= LSU_LB;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rd_q       <= 5'd0;
      err_q      <= 1'b0;
      mis_q      <= 1'b0;
      cnt_q      <= 16'd0;
      rd_o       <= 5'd0;
      rd_wdata_o <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= op_in;
            addr_q  <= {addr_i[31:2], align_low(op_in, addr_i[1:0])};
            wdata_q <= wdata_i;
            rd_q    <= rd_i;
            err_q   <= 1'b0;
            mis_q   <= trap;
            cnt_q   <= 16'd0;
            // A trapped access goes straight to RESP, so rd_o updates now.
            if (trap) rd_o <= rd_i;
          end
        end
        ST_REQ: begin
          if (mem_ready_i) begin
            rd_o <= rd_q;
            if (op_is_load(op_q)) rd_wdata_o <= load_data;
          end else if (cnt_q == TMO_LAST) begin
            err_q <= 1'b1;
            rd_o  <= rd_q;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_RESP: cnt_q <= 16'd0;
        default: ;
      endcase
    end
  end

  prirv32_lsu_align u_align (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (mem_rdata_i),
    .wstrb      (wstrb),
    .store_data (store_data),
    .load_data  (load_data)
  );

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_RESP);
  assign err_o       = done_o & err_q;
  assign misalign_o  = done_o & mis_q;
  assign rd_wr_en_o  = done_o & op_is_load(op_q) & ~err_q & ~mis_q & (rd_q != 5'd0);

  assign mem_valid_o = (state_q == ST_REQ);
  assign mem_addr_o  = mem_valid_o ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata_o = mem_valid_o ? store_data : 32'h0;
  assign mem_wstrb_o = mem_valid_o ? wstrb : 4'b0000;

endmodule
